// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 multiply post-processing stage.
//   EXP_BIAS     : default exponent bias of binary32
//   SP_EXP_MAX   : all-ones biased exponent (inf/overflow)
//   FLAG_*       : bit positions inside the {overflow, underflow, inexact} flag vector
//   fp32_t       : packed binary32 word
//   s1_reg_t     : payload carried from the normalize stage to the round/pack stage
package fp_pkg;

  localparam int EXP_BIAS   = 127;
  localparam int SP_EXP_MAX = 255;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UDF = 1;
  localparam int FLAG_INX = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  // norm holds product bits [47:22]: 24 mantissa bits, guard, and one
  // sticky-candidate bit; everything below is folded into sticky.
  typedef struct packed {
    logic        sign;
    logic [10:0] e;
    logic [25:0] norm;
    logic        sticky;
    logic        tiny;
    logic        zero;
  } s1_reg_t;

endpackage

// File: rtl/lzc48.sv
// Combinational 48-bit leading-zero counter.
//   data_i     : value to scan
//   cnt_o      : number of zeros above the most significant one (0 when all zero)
//   all_zero_o : data_i has no bit set
module lzc48 (
  input  logic [47:0] data_i,
  output logic [5:0]  cnt_o,
  output logic        all_zero_o
);

  // Scanning upward, the last set bit seen is the most significant one.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 48; i++) begin
      if (data_i[i]) cnt_o = 6'(47 - i);
    end
  end

  assign all_zero_o = ~|data_i;

endmodule

// File: rtl/fp_mul_round_pack.sv
// Post-processing stage behind the single-precision mantissa multiplier:
// normalize, denormalize into the subnormal range, round to nearest-even and
// pack a binary32 result with {overflow, underflow, inexact} flags.
// Two register stages with valid/ready flow control, one result per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational)
//   in_sign             : product sign
//   in_exp              : sum of biased operand exponents
//   in_mant             : 48-bit mantissa product, binary point between bits 46 and 45
//   out_valid/out_ready : result handshake
//   out_result          : packed binary32
//   out_flags           : {overflow, underflow, inexact}
module fp_mul_round_pack #(
  parameter int EXP_BIAS = fp_pkg::EXP_BIAS,
  parameter bit FTZ      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [47:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  import fp_pkg::*;

  // ---------------------------------------------------------------- control
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // ------------------------------------------------------ stage 1: normalize
  logic [5:0]  lz;
  logic        mant_zero;
  logic [47:0] norm_full, norm_sh, sh_mask;
  logic [10:0] e_raw, sh_amt;
  logic        e_le0, sh_out;
  s1_reg_t     s1_d, s1_q;

  lzc48 u_lzc (
    .data_i     (in_mant),
    .cnt_o      (lz),
    .all_zero_o (mant_zero)
  );

  always_comb begin
    norm_full = in_mant << lz;
    // 11-bit two's complement: range is roughly -171..+382.
    e_raw  = 11'(in_exp) - 11'(EXP_BIAS) + 11'd1 - 11'(lz);
    e_le0  = e_raw[10] || (e_raw == '0);
    sh_amt = 11'd1 - e_raw;
    norm_sh = norm_full;
    sh_mask = '0;
    sh_out  = 1'b0;
    if (e_le0) begin
      if (sh_amt >= 11'd48) begin
        norm_sh = '0;
        sh_out  = |in_mant;
      end else begin
        sh_mask = ~({48{1'b1}} << sh_amt[5:0]);
        norm_sh = norm_full >> sh_amt[5:0];
        sh_out  = |(norm_full & sh_mask);
      end
    end

    s1_d      = '0;
    s1_d.sign = in_sign;
    if (mant_zero) begin
      s1_d.zero = 1'b1;
    end else begin
      s1_d.e      = e_le0 ? 11'd0 : e_raw;
      s1_d.norm   = norm_sh[47:22];
      s1_d.sticky = (|norm_sh[21:0]) | sh_out;
      s1_d.tiny   = e_le0;
    end
  end

  // -------------------------------------------------- stage 2: round & pack
  logic [23:0] m;
  logic        g, s, rup, inx, ovf, sub;
  logic [24:0] mr;
  logic [23:0] mr_n;
  logic [10:0] e2;
  logic [7:0]  exp_f;
  fp32_t       res_d, res_q;
  logic [2:0]  flg_d, flg_q;

  always_comb begin
    m   = s1_q.norm[25:2];
    g   = s1_q.norm[1];
    s   = s1_q.norm[0] | s1_q.sticky;
    rup = g & (s | m[0]);
    inx = g | s;
    mr  = {1'b0, m} + {24'd0, rup};
    // Carry out of the mantissa renormalizes by one position.
    mr_n = mr[24] ? mr[24:1] : mr[23:0];
    e2   = mr[24] ? s1_q.e + 11'd1 : s1_q.e;
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    exp_f = ((e2 == '0) && mr_n[23]) ? 8'd1 : e2[7:0];
    ovf   = e2 >= 11'(SP_EXP_MAX);
    sub   = (e2 == '0) && !mr_n[23];

    res_d.sign = s1_q.sign;
    res_d.exp  = exp_f;
    res_d.frac = mr_n[22:0];
    flg_d           = '0;
    flg_d[FLAG_UDF] = s1_q.tiny & inx;
    flg_d[FLAG_INX] = inx;

    if (s1_q.zero) begin
      res_d.exp  = '0;
      res_d.frac = '0;
      flg_d      = '0;
    end else if (ovf) begin
      res_d.exp       = 8'hFF;
      res_d.frac      = '0;
      flg_d           = '0;
      flg_d[FLAG_OVF] = 1'b1;
      flg_d[FLAG_INX] = 1'b1;
    end else if (FTZ && sub) begin
      // Input was nonzero, so a flushed subnormal is always lossy.
      res_d.exp       = '0;
      res_d.frac      = '0;
      flg_d[FLAG_UDF] = 1'b1;
      flg_d[FLAG_INX] = 1'b1;
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
      flg_q      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q <= res_d;
          flg_q <= flg_d;
        end
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;

endmodule
